mux_seq_n: RTL and testbench

- Parametrised, registered N-input selector for real-valued matrix operands.
- Two modes:
  - Direct: one selected element per accepted beat.
  - Sweep: snapshots all N inputs, then streams a contiguous, wrap-around run of them serially.
- Sits between a matrix row/column buffer and a multiply-accumulate lane, feeding one operand per cycle.
- Valid/ready on both sides.

---
 rtl/mux_seq_pkg.sv | 25 ++
 rtl/mux_seq_n_real_bank.sv | 34 +++
 rtl/mux_seq_n.sv | 122 ++++++++++++
 tb/tb_mux_seq_n.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the registered N-input operand selector.
package mux_seq_pkg;

  localparam int RW = 64;

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_t;

  function automatic int clamp_len(
    input int len,
    input int n
  );
    return (len == 0 || len > n) ? n : len;
  endfunction

  function automatic int wrap_inc(
    input int idx,
    input int n
  );
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_seq_n_real_bank.sv
// Snapshot register file: load-all, one async read port, sync clear.
module real_bank
  import mux_seq_pkg::*;
#(
  parameter int N = 8,
  localparam int AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [N-1:0][RW-1:0]  din,
  input  logic [AW-1:0]         rd_idx,
  output logic [RW-1:0]         rd_data
);

  logic [N-1:0][RW-1:0] mem;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
    end else if (load) begin
      mem <= din;
    end
  end

  // Guard reads beyond N when N is not a power of two.
  always_comb begin
    rd_data = '0;
    if (32'(rd_idx) < N) begin
      rd_data = mem[rd_idx];
    end
  end

endmodule

// File: rtl/mux_seq_n.sv
// Registered N-input selector: direct single beats or a wrapped sweep
// streamed from a snapshot of all inputs.
module mux_seq_n
  import mux_seq_pkg::*;
#(
  parameter int NUM_IN = 8,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0][RW-1:0] in,
  input  logic [SEL_W-1:0]          switch,
  input  logic                      mode,
  input  logic [SEL_W:0]            sweep_len,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [RW-1:0]             out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_last,
  output logic                      out_err,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam logic [SEL_W:0] REM_ONE = (SEL_W+1)'(1);

  state_t state;
  state_t state_n;

  logic [SEL_W-1:0] idx;
  logic [SEL_W:0]   rem;
  logic [RW-1:0]    bank_rd;

  logic free;
  logic bad;
  logic accept;
  logic sweep_acc;
  logic load_beat;

  assign free = !out_valid || out_ready;
  assign bad  = 32'(switch) >= NUM_IN;
  assign busy = (state == S_SWEEP);

  real_bank #(
    .N (NUM_IN)
  ) u_bank (
    .clk     (clk),
    .clr     (rst),
    .load    (sweep_acc),
    .din     (in),
    .rd_idx  (idx),
    .rd_data (bank_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    sweep_acc = 1'b0;
    load_beat = 1'b0;
    unique case (state)
      S_IDLE: begin
        in_ready = !rst && free;
        accept   = in_valid && in_ready;
        if (accept && mode && !bad) begin
          sweep_acc = 1'b1;
          state_n   = S_SWEEP;
        end
      end
      S_SWEEP: begin
        load_beat = free && !rst;
        if (load_beat && rem == REM_ONE) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_sel   <= '0;
      out_last  <= 1'b0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      idx       <= '0;
      rem       <= '0;
    end else if (load_beat) begin
      out       <= bank_rd;
      out_sel   <= idx;
      out_last  <= (rem == REM_ONE);
      out_err   <= 1'b0;
      out_valid <= 1'b1;
      idx       <= SEL_W'(wrap_inc(int'(idx), NUM_IN));
      rem       <= rem - REM_ONE;
    end else if (sweep_acc) begin
      // First sweep beat comes from the bank on the following edge.
      idx       <= switch;
      rem       <= (SEL_W+1)'(clamp_len(int'(sweep_len), NUM_IN));
      out_valid <= 1'b0;
    end else if (accept) begin
      out       <= bad ? '0 : in[switch];
      out_sel   <= switch;
      out_last  <= 1'b1;
      out_err   <= bad;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_seq_n.sv
// Self-checking bench for mux_seq_n: directed steps plus random traffic
// against a queue-based model of the expected beat stream.
module tb_mux_seq_n;

  localparam int N  = 8;
  localparam int SW = $clog2(N);

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0][63:0] in_bus;
  logic [SW-1:0]      switch;
  logic               mode;
  logic [SW:0]        sweep_len;
  logic               in_valid;
  logic               in_ready;
  logic [63:0]        out;
  logic [SW-1:0]      out_sel;
  logic               out_last;
  logic               out_err;
  logic               out_valid;
  logic               out_ready;
  logic               busy;

  mux_seq_n #(
    .NUM_IN (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in_bus),
    .switch    (switch),
    .mode      (mode),
    .sweep_len (sweep_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] v;
    int          s;
    logic        l;
  } beat_t;

  beat_t q[$];
  int    beat_cyc[$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    beats = 0;
  bit    rnd_on = 0;

  logic        held = 1'b0;
  logic [63:0] p_out;
  logic [SW-1:0] p_sel;
  logic        p_last;
  logic        p_err;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic set_ramp();
    for (int k = 0; k < N; k++) in_bus[k] = $realtobits(k + 0.5);
  endtask

  // Reference: a request expands into the list of beats it must produce.
  task automatic model_push(input logic m, input int sw, input int len);
    beat_t b;
    int    n;
    if (!m) begin
      b.v = in_bus[sw];
      b.s = sw;
      b.l = 1'b1;
      q.push_back(b);
    end else begin
      n = (len == 0 || len > N) ? N : len;
      for (int k = 0; k < n; k++) begin
        b.v = in_bus[(sw + k) % N];
        b.s = (sw + k) % N;
        b.l = (k == n - 1);
        q.push_back(b);
      end
    end
  endtask

  task automatic send(input logic m, input int sw, input int len);
    int n;
    mode      = m;
    switch    = SW'(sw);
    sweep_len = (SW+1)'(len);
    in_valid  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'd1, 64'd0);
    else model_push(m, sw, len);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!rst && out_valid) begin
      if (held) begin
        chk("hold_out", out, p_out);
        chk("hold_sel", 64'(out_sel), 64'(p_sel));
        chk("hold_last", 64'(out_last), 64'(p_last));
      end
      if (out_ready) begin
        if (q.size() == 0) begin
          chk("extra_beat", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("beat_val", out, e.v);
          chk("beat_sel", 64'(out_sel), 64'(e.s));
          chk("beat_last", 64'(out_last), 64'(e.l));
          chk("beat_err", 64'(out_err), 64'd0);
        end
        beat_cyc.push_back(cyc);
        beats++;
      end
    end
    held   = !rst && out_valid && !out_ready;
    p_out  = out;
    p_sel  = out_sel;
    p_last = out_last;
    p_err  = out_err;
  end

  // Random downstream stalls and input churn, enabled for the soak phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) begin
        out_ready = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < N; k++) in_bus[k] = {$urandom, $urandom};
      end
    end
  end

  initial begin
    int n;
    int b0;
    rst = 1'b1;
    in_valid = 1'b0;
    mode = 1'b0;
    switch = '0;
    sweep_len = '0;
    out_ready = 1'b1;
    set_ramp();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_out", out, 64'd0);
    chk("rst_sel", 64'(out_sel), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_err", 64'(out_err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    send(1'b0, 5, 0);
    chk("direct_valid", 64'(out_valid), 64'd1);
    chk("direct_val", out, $realtobits(5.5));
    chk("direct_sel", 64'(out_sel), 64'd5);
    chk("direct_last", 64'(out_last), 64'd1);
    drain();

    beat_cyc.delete();
    send(1'b0, 0, 0);
    send(1'b0, 7, 0);
    send(1'b0, 3, 0);
    drain();
    chk("burst_cnt", 64'(beat_cyc.size()), 64'd3);
    if (beat_cyc.size() == 3) begin
      chk("burst_gap1", 64'(beat_cyc[1] - beat_cyc[0]), 64'd1);
      chk("burst_gap2", 64'(beat_cyc[2] - beat_cyc[1]), 64'd1);
    end

    send(1'b1, 6, 4);
    chk("sweep_busy", 64'(busy), 64'd1);
    chk("sweep_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("sweep_busy2", 64'(busy), 64'd1);
    chk("sweep_in_ready2", 64'(in_ready), 64'd0);
    drain();

    send(1'b1, 2, 0);
    for (int k = 0; k < N; k++) in_bus[k] = $realtobits(-1.0);
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    set_ramp();

    b0 = beats;
    send(1'b1, 0, 8);
    n = 0;
    while (beats < b0 + 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("pre_rst_beats", 64'(beats - b0), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out", out, 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_idle", 64'(out_valid), 64'd0);
    send(1'b0, 1, 0);
    chk("post_rst_val", out, $realtobits(1.5));
    drain();

    rnd_on = 1;
    for (int r = 0; r < 60; r++) begin
      send(1'(($urandom_range(0, 2)) == 0), int'($urandom_range(0, N - 1)),
           int'($urandom_range(0, N + 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    rnd_on = 0;
    #2;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
